// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch path.
package fetch_pkg;

  localparam int          ROM_AW    = 10;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Major opcodes, kept here so decode and benches use one definition.
  localparam logic [6:0] OP_I_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  // One instruction queue entry: the word and the byte address it came from.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fq_entry_t;

  // Decode may request 0..3; 3 means "as many as the two slots allow".
  function automatic logic [1:0] deq_request(input logic [1:0] d);
    return (d == 2'd3) ? 2'd2 : d;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bus bundle between the fetch sequencer, the instruction ROM and decode.
//
// Handshake: out0_valid/out1_valid mark presented slots (out1 only when
// out0 is valid). Decode reports how many slots it took this cycle on
// deq_cnt; taking more than are valid is a protocol error and is clipped.
// redirect_valid is a single-cycle command that flushes everything and
// restarts fetch at redirect_pc. The ROM has no handshake: rom_instr1/2
// always hold the words addressed by rom_addr on the previous cycle.
interface fetch_if #(
  parameter int AW = fetch_pkg::ROM_AW
);
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_instr1;
  logic [31:0]   rom_instr2;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [1:0]    deq_cnt;
  logic          out0_valid;
  logic [31:0]   out0_instr;
  logic [31:0]   out0_pc;
  logic          out1_valid;
  logic [31:0]   out1_instr;
  logic [31:0]   out1_pc;

  modport master (
    output rom_addr,
    input  rom_instr1, rom_instr2,
    input  redirect_valid, redirect_pc, deq_cnt,
    output out0_valid, out0_instr, out0_pc,
    output out1_valid, out1_instr, out1_pc
  );

  modport slave (
    input  rom_addr,
    output rom_instr1, rom_instr2,
    output redirect_valid, redirect_pc, deq_cnt,
    input  out0_valid, out0_instr, out0_pc,
    input  out1_valid, out1_instr, out1_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular buffer of {instr, pc} with up to two reads and two writes per
// cycle. The caller never writes more than the free space after reads.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [1:0]    rd_cnt,
  input  logic [1:0]    wr_cnt,
  input  fq_entry_t     wr0,
  input  fq_entry_t     wr1,
  output fq_entry_t     rd0,
  output fq_entry_t     rd1,
  output logic [CW-1:0] count
);

  fq_entry_t     mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  assign rd0 = mem[head];
  assign rd1 = mem[head + PW'(1)];

  // Pointer and occupancy update; clear wins over any read or write.
  always_ff @(posedge clk) begin
    if (clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(rd_cnt);
      tail  <= tail + PW'(wr_cnt);
      count <= count - CW'(rd_cnt) + CW'(wr_cnt);
    end
  end

  // Storage writes at the tail; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (!clr && wr_cnt != 2'd0) mem[tail] <= wr0;
    if (!clr && wr_cnt == 2'd2) mem[tail + PW'(1)] <= wr1;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues paired ROM reads when the queue
// has room for the returning pair, and presents the two oldest
// instructions to decode.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          QDEPTH   = 4,
  parameter int          ROM_AW   = fetch_pkg::ROM_AW,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [31:0]   pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [CW-1:0] count;
  logic [1:0]    deq_req;
  logic [1:0]    deq_eff;
  logic [1:0]    enq_cnt;
  logic [CW:0]   count_after;
  logic          fire;
  logic          flush;
  logic          pc_last;
  logic          inflight_last;
  fq_entry_t     wr0, wr1, rd0, rd1;

  assign flush         = rst | bus.redirect_valid;
  assign pc_last       = &pc[ROM_AW+1:2];
  assign inflight_last = &inflight_pc[ROM_AW+1:2];
  assign bus.rom_addr  = pc[ROM_AW+1:2];

  // Occupancy bookkeeping: clip the dequeue, size the returning pair and
  // fetch only when the whole next pair is guaranteed a slot.
  always_comb begin
    deq_req     = deq_request(bus.deq_cnt);
    deq_eff     = (CW'(deq_req) > count) ? count[1:0] : deq_req;
    enq_cnt     = inflight ? (inflight_last ? 2'd1 : 2'd2) : 2'd0;
    count_after = (CW+1)'(count) - (CW+1)'(deq_eff) + (CW+1)'(enq_cnt);
    fire        = !flush &&
                  (({1'b0, count_after} + (CW+2)'(2)) <= (CW+2)'(QDEPTH));
    wr0         = '{instr: bus.rom_instr1, pc: inflight_pc};
    wr1         = '{instr: bus.rom_instr2, pc: inflight_pc + 32'd4};
  end

  // PC and in-flight tracking; the last ROM word has no partner, so the
  // PC advances by one word there instead of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.redirect_valid) begin
      pc          <= bus.redirect_pc & ~32'd3;
      inflight    <= 1'b0;
    end else if (fire) begin
      pc          <= pc + (pc_last ? 32'd4 : 32'd8);
      inflight    <= 1'b1;
      inflight_pc <= pc;
    end else begin
      inflight    <= 1'b0;
    end
  end

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk    (clk),
    .clr    (flush),
    .rd_cnt (deq_eff),
    .wr_cnt (enq_cnt),
    .wr0    (wr0),
    .wr1    (wr1),
    .rd0    (rd0),
    .rd1    (rd1),
    .count  (count)
  );

  // Present the queue head; empty slots show a NOP at pc 0.
  always_comb begin
    bus.out0_valid = (count >= CW'(1));
    bus.out1_valid = (count >= CW'(2));
    bus.out0_instr = bus.out0_valid ? rd0.instr : NOP_INSTR;
    bus.out0_pc    = bus.out0_valid ? rd0.pc    : 32'd0;
    bus.out1_instr = bus.out1_valid ? rd1.instr : NOP_INSTR;
    bus.out1_pc    = bus.out1_valid ? rd1.pc    : 32'd0;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: behavioural ROM, program-order queue model,
// per-cycle comparison and directed scenarios with literal expectations.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int QD = 4;
  localparam int AW = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if #(.AW(AW)) bus ();

  fetch_ctrl #(.QDEPTH(QD), .ROM_AW(AW), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- ROM ----------------
  function automatic logic [31:0] rom_word(input logic [AW-1:0] idx);
    return 32'hC000_0003 | (32'(idx) << 4);
  endfunction

  always @(posedge clk) begin
    bus.rom_instr1 <= rom_word(bus.rom_addr);
    bus.rom_instr2 <= rom_word(bus.rom_addr + AW'(1));
  end

  // ---------------- reference model ----------------
  // exp_q holds the PCs decode should see, oldest first.
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_infl_pc;
  bit          m_infl;
  bit          model_live = 1'b0;

  always @(posedge clk) begin
    int take;
    if (rst) begin
      exp_q.delete();
      m_infl     = 1'b0;
      m_pc       = 32'h0;
      model_live = 1'b1;
    end else if (bus.redirect_valid) begin
      exp_q.delete();
      m_infl = 1'b0;
      m_pc   = bus.redirect_pc & ~32'd3;
    end else begin
      take = (bus.deq_cnt == 2'd3) ? 2 : int'(bus.deq_cnt);
      if (take > exp_q.size()) take = exp_q.size();
      repeat (take) void'(exp_q.pop_front());
      if (m_infl) begin
        exp_q.push_back(m_infl_pc);
        if (m_infl_pc[AW+1:2] != {AW{1'b1}}) exp_q.push_back(m_infl_pc + 32'd4);
      end
      if (exp_q.size() + 2 <= QD) begin
        m_infl    = 1'b1;
        m_infl_pc = m_pc;
        m_pc      = m_pc + ((m_pc[AW+1:2] == {AW{1'b1}}) ? 32'd4 : 32'd8);
      end else begin
        m_infl = 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [31:0] p0, p1, e0_pc, e1_pc, e0_i, e1_i, e_addr;
    if (model_live) begin
      p0 = (exp_q.size() >= 1) ? exp_q[0] : 32'h0;
      p1 = (exp_q.size() >= 2) ? exp_q[1] : 32'h0;
      e0_pc = p0;
      e1_pc = p1;
      e0_i  = (exp_q.size() >= 1) ? rom_word(p0[AW+1:2]) : NOP_INSTR;
      e1_i  = (exp_q.size() >= 2) ? rom_word(p1[AW+1:2]) : NOP_INSTR;
      e_addr = 32'(m_pc[AW+1:2]);
      check("out0_valid", 32'(bus.out0_valid), 32'(exp_q.size() >= 1));
      check("out1_valid", 32'(bus.out1_valid), 32'(exp_q.size() >= 2));
      check("out0_pc", bus.out0_pc, e0_pc);
      check("out1_pc", bus.out1_pc, e1_pc);
      check("out0_instr", bus.out0_instr, e0_i);
      check("out1_instr", bus.out1_instr, e1_i);
      check("rom_addr", 32'(bus.rom_addr), e_addr);
    end
  end

  // ---------------- driver ----------------
  // Applies one cycle of inputs and returns after the edge has settled.
  // deq requests are clipped to what is presented, except that a raw 3
  // is kept whenever two entries are available.
  task automatic drive(input int want, input bit rv, input logic [31:0] rp, input bit rs);
    int sz;
    logic [1:0] d;
    sz = exp_q.size();
    if (want >= 2 && sz >= 2) d = 2'(want);
    else d = 2'((want < sz) ? want : sz);
    rst                = rs;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    bus.deq_cnt        = d;
    @(negedge clk);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.deq_cnt        = 2'd0;
    @(negedge clk);

    // Streaming at two per cycle from reset.
    repeat (3) drive(0, 0, 0, 1);
    drive(2, 0, 0, 0);
    check("t1_first_empty", 32'(bus.out0_valid), 32'd0);
    drive(2, 0, 0, 0);
    check("t1_out0_pc", bus.out0_pc, 32'h0);
    check("t1_out1_pc", bus.out1_pc, 32'h4);
    check("t1_out0_instr", bus.out0_instr, 32'hC000_0003);
    check("t1_out1_instr", bus.out1_instr, 32'hC000_0013);
    drive(2, 0, 0, 0);
    check("t1_pair2_pc0", bus.out0_pc, 32'h8);
    check("t1_pair2_pc1", bus.out1_pc, 32'hC);
    drive(2, 0, 0, 0);
    check("t1_pair3_pc0", bus.out0_pc, 32'h10);
    check("t1_pair3_pc1", bus.out1_pc, 32'h14);
    repeat (6) drive(2, 0, 0, 0);

    // Full stall, then resume (first resume uses a raw deq_cnt of 3).
    drive(0, 0, 0, 1);
    repeat (10) drive(0, 0, 0, 0);
    check("t2_rom_addr_frozen", 32'(bus.rom_addr), 32'd4);
    check("t2_full_out1", 32'(bus.out1_valid), 32'd1);
    check("t2_head_pc", bus.out0_pc, 32'h0);
    drive(3, 0, 0, 0);
    check("t2_resume_pc", bus.out0_pc, 32'h8);
    repeat (6) drive(2, 0, 0, 0);

    // One per cycle.
    drive(0, 0, 0, 1);
    repeat (5) drive(1, 0, 0, 0);
    check("t3_out0_pc", bus.out0_pc, 32'hC);
    repeat (10) drive(1, 0, 0, 0);

    // Redirect with a pair in flight, then back-to-back redirects on a full queue.
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 1, 32'h42, 0);
    check("t4_rom_addr", 32'(bus.rom_addr), 32'h10);
    check("t4_flushed", 32'(bus.out0_valid), 32'd0);
    drive(2, 0, 0, 0);
    check("t4_still_empty", 32'(bus.out0_valid), 32'd0);
    drive(2, 0, 0, 0);
    check("t4_target_pc", bus.out0_pc, 32'h40);
    check("t4_target_pc1", bus.out1_pc, 32'h44);
    check("t4_target_instr", bus.out0_instr, 32'hC000_0103);
    repeat (3) drive(2, 0, 0, 0);
    repeat (6) drive(0, 0, 0, 0);
    drive(0, 1, 32'h100, 0);
    drive(0, 1, 32'h200, 0);
    drive(2, 0, 0, 0);
    drive(2, 0, 0, 0);
    check("t4_last_redirect", bus.out0_pc, 32'h200);
    repeat (3) drive(2, 0, 0, 0);

    // Last ROM word and address wrap.
    drive(0, 1, 32'hFFC, 0);
    drive(0, 0, 0, 0);
    check("t5_rom_addr_wrap", 32'(bus.rom_addr), 32'd0);
    drive(0, 0, 0, 0);
    check("t5_single_pc", bus.out0_pc, 32'hFFC);
    check("t5_single_only", 32'(bus.out1_valid), 32'd0);
    check("t5_out1_nop", bus.out1_instr, NOP_INSTR);
    drive(0, 0, 0, 0);
    check("t5_next_pc", bus.out1_pc, 32'h1000);
    check("t5_next_instr", bus.out1_instr, 32'hC000_0003);
    repeat (4) drive(2, 0, 0, 0);

    // Reset in the middle of a stream.
    repeat (4) drive(1, 0, 0, 0);
    drive(0, 0, 0, 1);
    check("t6_out0_valid", 32'(bus.out0_valid), 32'd0);
    check("t6_out1_valid", 32'(bus.out1_valid), 32'd0);
    check("t6_out0_instr", bus.out0_instr, NOP_INSTR);
    check("t6_out0_pc", bus.out0_pc, 32'h0);
    drive(2, 0, 0, 0);
    check("t6_gap", 32'(bus.out0_valid), 32'd0);
    drive(2, 0, 0, 0);
    check("t6_restart_valid", 32'(bus.out0_valid), 32'd1);
    check("t6_restart_pc", bus.out0_pc, 32'h0);
    repeat (3) drive(2, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
